// File: rtl/io_mmio_pkg.sv
// -----------------------------------------------------------------------------
// io_mmio_pkg
// Shared definitions for the UART memory-mapped controller:
//   - register offsets inside the IO window
//   - bit positions of the status word and of the control word
//   - TX sequencer state type
//   - helper that assembles the status word
// -----------------------------------------------------------------------------
package io_mmio_pkg;

  // Register offsets relative to the window base
  localparam logic [31:0] OFF_STATUS = 32'h0000_0000;
  localparam logic [31:0] OFF_RX     = 32'h0000_0004;
  localparam logic [31:0] OFF_TX     = 32'h0000_0008;
  localparam logic [31:0] OFF_CTRL   = 32'h0000_000C;

  // Status word bit positions
  localparam int STAT_TX_NOT_FULL = 0;
  localparam int STAT_RX_VALID    = 1;
  localparam int STAT_TX_EMPTY    = 2;
  localparam int STAT_RX_OVERRUN  = 3;

  // Control word bit positions
  localparam int CTRL_FLUSH       = 0;
  localparam int CTRL_CLR_OVERRUN = 1;

  // TX sequencer: IDLE has nothing on the UART, PRESENT holds a valid byte
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } tx_state_t;

  // Build the 32-bit status word; unused upper bits read as zero
  function automatic logic [31:0] pack_status(
    input logic rx_overrun,
    input logic tx_empty,
    input logic rx_valid,
    input logic tx_not_full
  );
    logic [31:0] s;
    s = '0;
    s[STAT_RX_OVERRUN]  = rx_overrun;
    s[STAT_TX_EMPTY]    = tx_empty;
    s[STAT_RX_VALID]    = rx_valid;
    s[STAT_TX_NOT_FULL] = tx_not_full;
    return s;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// -----------------------------------------------------------------------------
// io_tx_fifo
// Synchronous FIFO for outgoing UART bytes. Head is visible combinationally so
// the sequencer can load it into its output register on the same edge it pops.
// Pointers carry one extra wrap bit to tell full from empty.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write din when not full
//   pop           advance read pointer when not empty
//   flush         discard all entries (overrides push/pop on that edge)
//   full, empty   occupancy flags
//   head          oldest entry (undefined when empty)
// -----------------------------------------------------------------------------
module io_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Same index with differing wrap bits means the writer lapped the reader
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign head = mem[rd_ptr_reg[AW-1:0]];

  // Storage carries no reset; stale contents are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// uart_mmio_ctrl
// Bridges CPU loads/stores in a four-register IO window to a UART byte
// interface. Outgoing bytes queue in io_tx_fifo and are drained by a registered
// valid/ready sequencer; incoming bytes land in a single holding register with
// overrun detection. Stall is the only combinational input-to-output path.
//
// Ports:
//   Clock, Reset       system clock, asynchronous active-high reset
//   Addr               CPU access address (exact match decode)
//   WriteData          store data, bits [7:0] used
//   WriteEn, ReadEn    store / load strobes
//   ReadData           registered load data, valid the cycle after the load
//   Stall              CPU must hold a TX store while the FIFO is full
//   UartDataIn/Valid   TX byte and valid toward the UART
//   UartDataInReady    UART accepts the TX byte
//   UartDataOut/Valid  RX byte and one-cycle valid pulse from the UART
//   UartDataOutReady   constant 1, RX is never back-pressured
// -----------------------------------------------------------------------------
module uart_mmio_ctrl
  import io_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          TX_DEPTH  = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        WriteEn,
  input  logic        ReadEn,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic [7:0]  UartDataIn,
  output logic        UartDataInValid,
  input  logic        UartDataInReady,
  input  logic [7:0]  UartDataOut,
  input  logic        UartDataOutValid,
  output logic        UartDataOutReady
);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic hit_status;
  logic hit_rx;
  logic hit_tx;
  logic hit_ctrl;

  assign hit_status = (Addr == BASE_ADDR + OFF_STATUS);
  assign hit_rx     = (Addr == BASE_ADDR + OFF_RX);
  assign hit_tx     = (Addr == BASE_ADDR + OFF_TX);
  assign hit_ctrl   = (Addr == BASE_ADDR + OFF_CTRL);

  // Only the low byte of store data is meaningful
  logic unused_wdata;
  assign unused_wdata = ^WriteData[31:8];

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       fifo_pop;
  logic       tx_push;
  logic       tx_flush;

  // Full is judged before any same-edge pop, so a stalled store never sneaks in
  assign Stall    = WriteEn & hit_tx & fifo_full;
  assign tx_push  = WriteEn & hit_tx & ~fifo_full;
  assign tx_flush = WriteEn & hit_ctrl & WriteData[CTRL_FLUSH];

  io_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (tx_push),
    .pop   (fifo_pop),
    .flush (tx_flush),
    .din   (WriteData[7:0]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // ---------------------------------------------------------------------------
  // TX sequencer
  // ---------------------------------------------------------------------------
  tx_state_t  state_reg;
  tx_state_t  state_next;
  logic [7:0] tx_data_reg;

  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        // On a completed handshake refill straight from the FIFO so a
        // continuously ready UART sees one byte per cycle
        if (UartDataInReady) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg   <= IDLE;
      tx_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      // A flush on the same edge still lets the popped byte go out: it has
      // already left the queue and becomes the in-flight byte
      if (fifo_pop) begin
        tx_data_reg <= fifo_head;
      end
    end
  end

  // Valid comes straight from the state flop, so reset drops it immediately
  assign UartDataInValid = (state_reg == PRESENT);
  assign UartDataIn      = tx_data_reg;

  logic tx_empty;
  assign tx_empty = fifo_empty & (state_reg == IDLE);

  // ---------------------------------------------------------------------------
  // RX holding register
  // ---------------------------------------------------------------------------
  logic [7:0] rx_hold_reg;
  logic       rx_valid_reg;
  logic       rx_overrun_reg;
  logic       rx_pop;
  logic       rx_capture;
  logic       rx_drop;
  logic       status_read;
  logic       overrun_clear;

  assign status_read   = ReadEn & hit_status;
  assign rx_pop        = ReadEn & hit_rx & rx_valid_reg;
  // A same-edge pop frees the register, so the new byte is taken, not dropped
  assign rx_capture    = UartDataOutValid & (~rx_valid_reg | rx_pop);
  assign rx_drop       = UartDataOutValid & rx_valid_reg & ~rx_pop;
  assign overrun_clear = status_read | (WriteEn & hit_ctrl & WriteData[CTRL_CLR_OVERRUN]);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rx_hold_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      if (rx_capture) begin
        rx_hold_reg  <= UartDataOut;
        rx_valid_reg <= 1'b1;
      end else if (rx_pop) begin
        rx_valid_reg <= 1'b0;
      end
      // A fresh overrun outranks a clear landing on the same edge
      if (rx_drop) begin
        rx_overrun_reg <= 1'b1;
      end else if (overrun_clear) begin
        rx_overrun_reg <= 1'b0;
      end
    end
  end

  assign UartDataOutReady = 1'b1;

  // ---------------------------------------------------------------------------
  // Load data path: sampled from pre-edge state, so a status read shows the
  // overrun flag as it was before the clear it triggers
  // ---------------------------------------------------------------------------
  logic [31:0] read_next;

  always_comb begin
    read_next = '0;
    if (ReadEn) begin
      if (hit_status) begin
        read_next = pack_status(rx_overrun_reg, tx_empty, rx_valid_reg, ~fifo_full);
      end else if (hit_rx && rx_valid_reg) begin
        read_next = {24'b0, rx_hold_reg};
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ReadData <= '0;
    end else begin
      ReadData <= read_next;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_mmio_ctrl
// Directed steps from the test plan followed by a random phase. Expectations
// come from a queue-level reference model of the controller's rules.
// -----------------------------------------------------------------------------
module tb_uart_mmio_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] A_ST  = BASE + 32'h0;
  localparam logic [31:0] A_RX  = BASE + 32'h4;
  localparam logic [31:0] A_TX  = BASE + 32'h8;
  localparam logic [31:0] A_CT  = BASE + 32'hC;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic        WriteEn = 1'b0;
  logic        ReadEn = 1'b0;
  logic [31:0] ReadData;
  logic        Stall;
  logic [7:0]  UartDataIn;
  logic        UartDataInValid;
  logic        UartDataInReady = 1'b0;
  logic [7:0]  UartDataOut = '0;
  logic        UartDataOutValid = 1'b0;
  logic        UartDataOutReady;

  uart_mmio_ctrl #(
    .BASE_ADDR (BASE),
    .TX_DEPTH  (DEPTH)
  ) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .Addr             (Addr),
    .WriteData        (WriteData),
    .WriteEn          (WriteEn),
    .ReadEn           (ReadEn),
    .ReadData         (ReadData),
    .Stall            (Stall),
    .UartDataIn       (UartDataIn),
    .UartDataInValid  (UartDataInValid),
    .UartDataInReady  (UartDataInReady),
    .UartDataOut      (UartDataOut),
    .UartDataOutValid (UartDataOutValid),
    .UartDataOutReady (UartDataOutReady)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes waiting, byte on the wire, RX hold state
  logic [7:0] m_fifo[$];
  bit         m_pres;
  logic [7:0] m_pres_b;
  bit         m_rxv;
  logic [7:0] m_rxh;
  bit         m_ovr;
  bit         obs_stall;

  logic [31:0] others [4] = '{BASE + 32'h1, BASE + 32'h10, 32'h0000_0008, BASE + 32'hD};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_pres   = 1'b0;
    m_pres_b = '0;
    m_rxv    = 1'b0;
    m_rxh    = '0;
    m_ovr    = 1'b0;
  endtask

  // One clock of stimulus; model advanced by the documented rules
  task automatic cycle(input bit we, input bit re, input logic [31:0] addr,
                       input logic [31:0] wd, input bit rdy, input bit rxv,
                       input logic [7:0] rxd);
    bit          full_pre;
    bit          exp_stall;
    bit          pop_rx;
    bit          clr;
    logic [31:0] exp_rd;
    WriteEn          = we;
    ReadEn           = re;
    Addr             = addr;
    WriteData        = wd;
    UartDataInReady  = rdy;
    UartDataOutValid = rxv;
    UartDataOut      = rxd;
    full_pre  = (m_fifo.size() == DEPTH);
    exp_stall = we && (addr == A_TX) && full_pre;
    #1;
    obs_stall = Stall;
    chk("stall", {31'b0, Stall}, {31'b0, exp_stall});
    exp_rd = '0;
    if (re && addr == A_ST)
      exp_rd = {28'b0, m_ovr, (m_fifo.size() == 0 && !m_pres), m_rxv, !full_pre};
    else if (re && addr == A_RX && m_rxv)
      exp_rd = {24'b0, m_rxh};
    // TX: completed handshake frees the wire, which takes the oldest waiting byte
    if (m_pres && rdy) m_pres = 1'b0;
    if (!m_pres && m_fifo.size() > 0) begin
      m_pres   = 1'b1;
      m_pres_b = m_fifo.pop_front();
    end
    if (we && addr == A_CT && wd[0]) m_fifo.delete();
    if (we && addr == A_TX && !full_pre) m_fifo.push_back(wd[7:0]);
    // RX
    pop_rx = re && (addr == A_RX) && m_rxv;
    clr    = (re && addr == A_ST) || (we && addr == A_CT && wd[1]);
    if (clr) m_ovr = 1'b0;
    if (rxv) begin
      if (!m_rxv || pop_rx) begin
        m_rxh = rxd;
        m_rxv = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (pop_rx) begin
      m_rxv = 1'b0;
    end
    @(posedge Clock);
    #1;
    if (re) chk("rdata", ReadData, exp_rd);
    chk("tx_valid", {31'b0, UartDataInValid}, {31'b0, m_pres});
    if (m_pres) chk("tx_data", {24'b0, UartDataIn}, {24'b0, m_pres_b});
    if (we || re || rxv)
      $display("[TB] t=%0t we=%0b re=%0b addr=%h wd=%h rdy=%0b rxv=%0b rxd=%h rd=%h stall=%0b txv=%0b txd=%h",
               $time, we, re, addr, wd, rdy, rxv, rxd, ReadData, obs_stall, UartDataInValid, UartDataIn);
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, rdy, 1'b0, 8'h00);
  endtask

  initial begin
    model_reset();
    // Reset state
    #1;
    chk("rst_rdata", ReadData, 32'h0);
    chk("rst_valid", {31'b0, UartDataInValid}, 32'h0);
    chk("rst_data", {24'b0, UartDataIn}, 32'h0);
    chk("rst_stall", {31'b0, Stall}, 32'h0);
    chk("rx_ready", {31'b0, UartDataOutReady}, 32'h1);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;

    cycle(0, 1, A_ST, 0, 0, 0, 0);
    chk("status_after_reset", ReadData, 32'h5);

    // Back-to-back TX with ready held high
    cycle(1, 0, A_TX, 32'h41, 1, 0, 0);
    chk("tx_lat_edge1", {31'b0, UartDataInValid}, 32'h0);
    cycle(1, 0, A_TX, 32'h42, 1, 0, 0);
    chk("tx_b41", {23'b0, UartDataInValid, UartDataIn}, 32'h141);
    cycle(1, 0, A_TX, 32'h43, 1, 0, 0);
    chk("tx_b42", {23'b0, UartDataInValid, UartDataIn}, 32'h142);
    idle(1);
    chk("tx_b43", {23'b0, UartDataInValid, UartDataIn}, 32'h143);
    idle(1);
    chk("tx_done", {31'b0, UartDataInValid}, 32'h0);

    // Fill with ready low: 4 queued plus 1 on the wire, 6th stalls
    for (int i = 0; i < 5; i++) cycle(1, 0, A_TX, 32'hB0 + i, 0, 0, 0);
    chk("no_stall_5th", {31'b0, obs_stall}, 32'h0);
    cycle(1, 0, A_TX, 32'hB5, 0, 0, 0);
    chk("stall_6th_a", {31'b0, obs_stall}, 32'h1);
    cycle(1, 0, A_TX, 32'hB5, 0, 0, 0);
    chk("stall_6th_b", {31'b0, obs_stall}, 32'h1);
    cycle(1, 0, A_TX, 32'hB5, 1, 0, 0);
    chk("stall_on_ready", {31'b0, obs_stall}, 32'h1);
    cycle(1, 0, A_TX, 32'hB5, 0, 0, 0);
    chk("accept_6th", {31'b0, obs_stall}, 32'h0);
    repeat (8) idle(1);

    // RX capture and pop
    cycle(0, 0, 0, 0, 0, 1, 8'h5A);
    cycle(0, 1, A_RX, 0, 0, 0, 0);
    chk("rx_5a", ReadData, 32'h5A);
    cycle(0, 1, A_ST, 0, 0, 0, 0);
    chk("rx_valid_dropped", ReadData, 32'h5);
    cycle(0, 1, A_RX, 0, 0, 0, 0);
    chk("rx_empty_read", ReadData, 32'h0);

    // Overrun, clear by status read, same-edge arrival+pop
    cycle(0, 0, 0, 0, 0, 1, 8'h11);
    cycle(0, 0, 0, 0, 0, 1, 8'h22);
    cycle(0, 1, A_ST, 0, 0, 0, 0);
    chk("ovr_status", ReadData, 32'hF);
    cycle(0, 1, A_ST, 0, 0, 0, 0);
    chk("ovr_cleared", ReadData, 32'h7);
    cycle(0, 1, A_RX, 0, 0, 1, 8'h33);
    chk("pop_old_byte", ReadData, 32'h11);
    cycle(0, 1, A_ST, 0, 0, 0, 0);
    chk("no_ovr_on_pop", ReadData, 32'h7);
    cycle(0, 1, A_RX, 0, 0, 0, 0);
    chk("new_byte_held", ReadData, 32'h33);

    // Overrun cleared through the control register
    cycle(0, 0, 0, 0, 0, 1, 8'h44);
    cycle(0, 0, 0, 0, 0, 1, 8'h55);
    cycle(1, 0, A_CT, 32'h2, 0, 0, 0);
    cycle(0, 1, A_ST, 0, 0, 0, 0);
    chk("ctrl_clr_ovr", ReadData, 32'h7);
    cycle(0, 1, A_RX, 0, 0, 0, 0);
    chk("hold_kept_44", ReadData, 32'h44);

    // Flush while a byte is on the wire
    cycle(1, 0, A_TX, 32'hA1, 0, 0, 0);
    cycle(1, 0, A_TX, 32'hA2, 0, 0, 0);
    cycle(1, 0, A_TX, 32'hA3, 0, 0, 0);
    cycle(1, 0, A_CT, 32'h1, 0, 0, 0);
    chk("flush_inflight", {23'b0, UartDataInValid, UartDataIn}, 32'h1A1);
    idle(0);
    idle(1);
    chk("flush_done", {31'b0, UartDataInValid}, 32'h0);
    cycle(0, 1, A_ST, 0, 0, 0, 0);
    chk("flush_tx_empty", ReadData, 32'h5);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      int          k;
      bit          we;
      bit          re;
      logic [31:0] a;
      logic [31:0] wd;
      k  = $urandom_range(0, 19);
      wd = $urandom;
      if (k < 4)       a = A_ST;
      else if (k < 8)  a = A_RX;
      else if (k < 16) a = A_TX;
      else if (k == 16) a = A_CT;
      else             a = others[$urandom_range(0, 3)];
      if (a == A_CT && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
      we = (k >= 8) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 1);
      re = !we && ($urandom_range(0, 9) < 7);
      cycle(we, re, a, wd, ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 3),
            8'($urandom));
    end
    repeat (8) idle(1);

    // Asynchronous reset in the middle of a transfer
    cycle(1, 0, A_TX, 32'hC1, 0, 0, 0);
    cycle(1, 0, A_TX, 32'hC2, 0, 0, 0);
    cycle(1, 0, A_TX, 32'hC3, 0, 0, 0);
    chk("pre_reset_valid", {31'b0, UartDataInValid}, 32'h1);
    WriteEn = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    chk("reset_drops_valid", {31'b0, UartDataInValid}, 32'h0);
    model_reset();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    cycle(0, 1, A_ST, 0, 0, 0, 0);
    chk("reset_status", ReadData, 32'h5);
    idle(1);
    chk("reset_discarded", {31'b0, UartDataInValid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
